// File: rtl/run_controller_if.sv
// Run-control handshake bundle between the run controller and its user.
// The controller takes the master side; the bench or SoC glue takes the slave side.
interface run_controller_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 start;
   logic                 halt;
   logic                 complete;
   logic                 finish;
   logic                 running;
   logic                 timed_out;
   logic [CNT_WIDTH-1:0] cycle_count;

   modport master (
      input  start,
      input  halt,
      output complete,
      output finish,
      output running,
      output timed_out,
      output cycle_count
   );

   modport slave (
      output start,
      output halt,
      input  complete,
      input  finish,
      input  running,
      input  timed_out,
      input  cycle_count
   );
endinterface

// File: rtl/run_controller.sv
// Run controller sitting upstream of the processor core. A run starts on
// `start`. It ends on a retired halt or when the cycle budget runs out. The
// controller raises `complete` towards the core, holds it for DRAIN_CYCLES
// edges, then raises `finish` and parks in DONE until reset. It also reports
// the elapsed cycle count and whether the budget ended the run.
module run_controller #(
   parameter int MAX_CYCLES   = 100,
   parameter int DRAIN_CYCLES = 1,
   parameter int CNT_WIDTH    = 32
) (
   input  logic              clk,
   input  logic              reset,
   run_controller_if.master  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
   // complete must rise with cycle_count at MAX_CYCLES-DRAIN_CYCLES so that
   // finish, DRAIN_CYCLES edges later, coincides with cycle_count=MAX_CYCLES.
   localparam logic [CNT_WIDTH-1:0] BUDGET    = CNT_WIDTH'(MAX_CYCLES - DRAIN_CYCLES);
   localparam logic [CNT_WIDTH-1:0] DRAIN_LEN = CNT_WIDTH'(DRAIN_CYCLES);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNT_WIDTH-1:0] drain_q, drain_d, drain_inc;
   logic                 complete_q, complete_d;
   logic                 finish_q, finish_d;
   logic                 running_q, running_d;
   logic                 timed_out_q, timed_out_d;

   assign cnt_inc   = cnt_q + ONE;
   assign drain_inc = drain_q + ONE;

   // State and every output flag are registered; reset clears all of them at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         drain_q     <= '0;
         complete_q  <= 1'b0;
         finish_q    <= 1'b0;
         running_q   <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         drain_q     <= drain_d;
         complete_q  <= complete_d;
         finish_q    <= finish_d;
         running_q   <= running_d;
         timed_out_q <= timed_out_d;
      end
   end

   // Next-state and next-output logic. Halt outranks the budget on the same edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_d     = drain_q;
      complete_d  = complete_q;
      finish_d    = finish_q;
      running_d   = running_q;
      timed_out_d = timed_out_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = RUN;
               cnt_d     = '0;
               drain_d   = '0;
               running_d = 1'b1;
            end
         end
         RUN: begin
            cnt_d = cnt_inc;
            if (bus.halt || (cnt_inc == BUDGET)) begin
               complete_d  = 1'b1;
               timed_out_d = !bus.halt;
               if (DRAIN_CYCLES == 0) begin
                  state_d   = DONE;
                  finish_d  = 1'b1;
                  running_d = 1'b0;
               end else begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end
         end
         DRAIN: begin
            cnt_d   = cnt_inc;
            drain_d = drain_inc;
            if (drain_inc == DRAIN_LEN) begin
               state_d   = DONE;
               finish_d  = 1'b1;
               running_d = 1'b0;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.complete    = complete_q;
   assign bus.finish      = finish_q;
   assign bus.running     = running_q;
   assign bus.timed_out   = timed_out_q;
   assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: one instance with default parameters and one with
// DRAIN_CYCLES=0, MAX_CYCLES=10. Each scenario pushes the expected complete and
// finish counts into a scoreboard when it starts a run. It pops that entry when
// the DUT raises complete.
module tb_run_controller;

   logic clk = 1'b0;
   logic ra;
   logic rb;

   always #5 clk = ~clk;

   run_controller_if #(.CNT_WIDTH(32)) ifa ();
   run_controller_if #(.CNT_WIDTH(32)) ifb ();

   run_controller #(.MAX_CYCLES(100), .DRAIN_CYCLES(1), .CNT_WIDTH(32)) dut_a (
      .clk   (clk),
      .reset (ra),
      .bus   (ifa)
   );

   run_controller #(.MAX_CYCLES(10), .DRAIN_CYCLES(0), .CNT_WIDTH(32)) dut_b (
      .clk   (clk),
      .reset (rb),
      .bus   (ifb)
   );

   typedef struct {
      int c_cnt;
      int f_cnt;
      bit to;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // {complete, finish, running, timed_out}
   function automatic logic [3:0] obs(input bit b);
      if (b) return {ifb.complete, ifb.finish, ifb.running, ifb.timed_out};
      return {ifa.complete, ifa.finish, ifa.running, ifa.timed_out};
   endfunction

   function automatic logic [31:0] cnt(input bit b);
      return b ? ifb.cycle_count : ifa.cycle_count;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit b, input bit halt_val);
      if (b) begin
         rb = 1'b1; ifb.start = 1'b0; ifb.halt = halt_val;
      end else begin
         ra = 1'b1; ifa.start = 1'b0; ifa.halt = halt_val;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (b) rb = 1'b0;
      else   ra = 1'b0;
   endtask

   task automatic start_run(input bit b, input int c, input int f, input bit to);
      @(negedge clk);
      if (b) ifb.start = 1'b1;
      else   ifa.start = 1'b1;
      sb.push_back('{c_cnt: c, f_cnt: f, to: to});
      step();
      if (b) ifb.start = 1'b0;
      else   ifa.start = 1'b0;
   endtask

   task automatic wait_cnt(input bit b, input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (cnt(b) == 32'(target)) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_flag(input bit b, input bit fin, input int budget, output bit ok);
      logic [3:0] o;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         o = obs(b);
         if ((fin && o[2]) || (!fin && o[3])) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b0);
      n_cmp++;
      if ({obs(1'b0), cnt(1'b0)} !== 36'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got flags=%b cnt=%0d, want flags=0000 cnt=0", obs(1'b0), cnt(1'b0));
      end
      repeat (3) step();
      n_cmp++;
      if ({obs(1'b0), cnt(1'b0)} !== 36'h0) begin
         n_err++;
         $display("FAIL idle_hold: got flags=%b cnt=%0d, want flags=0000 cnt=0", obs(1'b0), cnt(1'b0));
      end
   endtask

   task automatic test_timeout();
      bit   ok;
      exp_t e;
      do_reset(1'b0, 1'b0);
      start_run(1'b0, 99, 100, 1'b1);
      n_cmp++;
      if (obs(1'b0) !== 4'b0010 || cnt(1'b0) !== 32'd0) begin
         n_err++;
         $display("FAIL to_run_entry: got flags=%b cnt=%0d, want flags=0010 cnt=0", obs(1'b0), cnt(1'b0));
      end
      wait_flag(1'b0, 1'b0, 200, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'(e.c_cnt) || obs(1'b0) !== {3'b101, e.to}) begin
         n_err++;
         $display("FAIL to_complete: ok=%0b got flags=%b cnt=%0d, want flags=101%0b cnt=%0d", ok, obs(1'b0), cnt(1'b0), e.to, e.c_cnt);
      end
      wait_flag(1'b0, 1'b1, 10, ok);
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'(e.f_cnt) || obs(1'b0) !== {3'b110, e.to}) begin
         n_err++;
         $display("FAIL to_finish: ok=%0b got flags=%b cnt=%0d, want flags=110%0b cnt=%0d", ok, obs(1'b0), cnt(1'b0), e.to, e.f_cnt);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         n_cmp++;
         if (cnt(1'b0) !== 32'(e.f_cnt) || obs(1'b0) !== {3'b110, e.to}) begin
            n_err++;
            $display("FAIL to_frozen[%0d]: got flags=%b cnt=%0d, want flags=110%0b cnt=%0d", i, obs(1'b0), cnt(1'b0), e.to, e.f_cnt);
         end
      end
   endtask

   task automatic test_halt();
      bit   ok;
      exp_t e;
      do_reset(1'b0, 1'b0);
      start_run(1'b0, 41, 42, 1'b0);
      wait_cnt(1'b0, 40, 100, ok);
      ifa.halt = 1'b1;
      step();
      ifa.halt = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'(e.c_cnt) || obs(1'b0) !== {3'b101, e.to}) begin
         n_err++;
         $display("FAIL halt_complete: ok=%0b got flags=%b cnt=%0d, want flags=101%0b cnt=%0d", ok, obs(1'b0), cnt(1'b0), e.to, e.c_cnt);
      end
      step();
      n_cmp++;
      if (cnt(1'b0) !== 32'(e.f_cnt) || obs(1'b0) !== {3'b110, e.to}) begin
         n_err++;
         $display("FAIL halt_finish: got flags=%b cnt=%0d, want flags=110%0b cnt=%0d", obs(1'b0), cnt(1'b0), e.to, e.f_cnt);
      end
   endtask

   task automatic test_halt_at_budget();
      bit   ok;
      exp_t e;
      do_reset(1'b0, 1'b0);
      start_run(1'b0, 99, 100, 1'b0);
      wait_cnt(1'b0, 98, 200, ok);
      ifa.halt = 1'b1;
      step();
      ifa.halt = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'(e.c_cnt) || obs(1'b0) !== {3'b101, e.to}) begin
         n_err++;
         $display("FAIL tie_complete: ok=%0b got flags=%b cnt=%0d, want flags=101%0b cnt=%0d", ok, obs(1'b0), cnt(1'b0), e.to, e.c_cnt);
      end
      wait_flag(1'b0, 1'b1, 10, ok);
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'(e.f_cnt) || obs(1'b0) !== {3'b110, e.to}) begin
         n_err++;
         $display("FAIL tie_finish: ok=%0b got flags=%b cnt=%0d, want flags=110%0b cnt=%0d", ok, obs(1'b0), cnt(1'b0), e.to, e.f_cnt);
      end
   endtask

   task automatic test_drain0();
      bit   ok;
      exp_t e;
      do_reset(1'b1, 1'b0);
      start_run(1'b1, 10, 10, 1'b1);
      wait_cnt(1'b1, 9, 50, ok);
      n_cmp++;
      if (!ok || obs(1'b1) !== 4'b0010) begin
         n_err++;
         $display("FAIL d0_before: ok=%0b got flags=%b, want flags=0010", ok, obs(1'b1));
      end
      step();
      e = sb.pop_front();
      n_cmp++;
      if (cnt(1'b1) !== 32'(e.c_cnt) || cnt(1'b1) !== 32'(e.f_cnt) || obs(1'b1) !== {3'b110, e.to}) begin
         n_err++;
         $display("FAIL d0_end: got flags=%b cnt=%0d, want flags=110%0b cnt=%0d", obs(1'b1), cnt(1'b1), e.to, e.c_cnt);
      end
      repeat (3) step();
      n_cmp++;
      if (cnt(1'b1) !== 32'(e.f_cnt) || obs(1'b1) !== {3'b110, e.to}) begin
         n_err++;
         $display("FAIL d0_hold: got flags=%b cnt=%0d, want flags=110%0b cnt=%0d", obs(1'b1), cnt(1'b1), e.to, e.f_cnt);
      end
   endtask

   task automatic test_async_reset();
      bit   ok;
      exp_t e;
      do_reset(1'b0, 1'b0);
      start_run(1'b0, 99, 100, 1'b1);
      wait_cnt(1'b0, 57, 100, ok);
      void'(sb.pop_front());
      #2;
      ra = 1'b1;
      #1;
      n_cmp++;
      if (!ok || obs(1'b0) !== 4'b0000 || cnt(1'b0) !== 32'd0) begin
         n_err++;
         $display("FAIL async_reset: ok=%0b got flags=%b cnt=%0d, want flags=0000 cnt=0", ok, obs(1'b0), cnt(1'b0));
      end
      @(negedge clk);
      ra = 1'b0;
      start_run(1'b0, 99, 100, 1'b1);
      wait_flag(1'b0, 1'b0, 200, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'(e.c_cnt) || obs(1'b0) !== {3'b101, e.to}) begin
         n_err++;
         $display("FAIL rerun_complete: ok=%0b got flags=%b cnt=%0d, want flags=101%0b cnt=%0d", ok, obs(1'b0), cnt(1'b0), e.to, e.c_cnt);
      end
      wait_flag(1'b0, 1'b1, 10, ok);
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'(e.f_cnt) || obs(1'b0) !== {3'b110, e.to}) begin
         n_err++;
         $display("FAIL rerun_finish: ok=%0b got flags=%b cnt=%0d, want flags=110%0b cnt=%0d", ok, obs(1'b0), cnt(1'b0), e.to, e.f_cnt);
      end
   endtask

   task automatic test_ignore();
      bit   ok;
      exp_t e;
      do_reset(1'b0, 1'b1);
      repeat (5) step();
      n_cmp++;
      if (obs(1'b0) !== 4'b0000 || cnt(1'b0) !== 32'd0) begin
         n_err++;
         $display("FAIL idle_halt: got flags=%b cnt=%0d, want flags=0000 cnt=0", obs(1'b0), cnt(1'b0));
      end
      ifa.halt = 1'b0;
      start_run(1'b0, 99, 100, 1'b1);
      wait_cnt(1'b0, 10, 50, ok);
      ifa.start = 1'b1;
      step();
      ifa.start = 1'b0;
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'd11 || obs(1'b0) !== 4'b0010) begin
         n_err++;
         $display("FAIL run_start: ok=%0b got flags=%b cnt=%0d, want flags=0010 cnt=11", ok, obs(1'b0), cnt(1'b0));
      end
      wait_flag(1'b0, 1'b0, 200, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'(e.c_cnt) || obs(1'b0) !== {3'b101, e.to}) begin
         n_err++;
         $display("FAIL ign_complete: ok=%0b got flags=%b cnt=%0d, want flags=101%0b cnt=%0d", ok, obs(1'b0), cnt(1'b0), e.to, e.c_cnt);
      end
      ifa.halt = 1'b1;
      wait_flag(1'b0, 1'b1, 10, ok);
      n_cmp++;
      if (!ok || cnt(1'b0) !== 32'(e.f_cnt) || obs(1'b0) !== {3'b110, e.to}) begin
         n_err++;
         $display("FAIL drain_halt: ok=%0b got flags=%b cnt=%0d, want flags=110%0b cnt=%0d", ok, obs(1'b0), cnt(1'b0), e.to, e.f_cnt);
      end
      ifa.start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++;
         if (cnt(1'b0) !== 32'(e.f_cnt) || obs(1'b0) !== {3'b110, e.to}) begin
            n_err++;
            $display("FAIL done_hold[%0d]: got flags=%b cnt=%0d, want flags=110%0b cnt=%0d", i, obs(1'b0), cnt(1'b0), e.to, e.f_cnt);
         end
      end
      ifa.start = 1'b0;
      ifa.halt  = 1'b0;
   endtask

   initial begin
      ra = 1'b1;
      rb = 1'b1;
      ifa.start = 1'b0;
      ifa.halt  = 1'b0;
      ifb.start = 1'b0;
      ifb.halt  = 1'b0;
      test_reset();
      test_timeout();
      test_halt();
      test_halt_at_budget();
      test_drain0();
      test_async_reset();
      test_ignore();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Run-control stage directly upstream of the processor core. It generates the core's `complete` input and the bench-level `finish` request. It starts a run on `start` and ends it on either a retired-halt indication from the core or a cycle budget. It replaces ad-hoc `$time` checks in benches with a synthesizable, cycle-exact controller that also reports elapsed cycles and the termination cause.

Parameters:
MAX_CYCLES, 100, cycle budget per run (100 cycles at a 10 ns period is 1000 ns); legal range DRAIN_CYCLES < MAX_CYCLES ≤ 2^CNT_WIDTH-1
DRAIN_CYCLES, 1, cycles `complete` is held high before `finish` rises; 0 is legal
CNT_WIDTH, 32, width of the cycle counter

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
halt  input  1  core retired a halt instruction; sampled only in RUN
complete  output  1  drives processor `complete`; registered
finish  output  1  run over, bench may end simulation; registered, level
running  output  1  high in RUN and DRAIN
timed_out  output  1  run ended by budget, not by halt
cycle_count  output  CNT_WIDTH  edges elapsed since leaving IDLE

Behaviour:
- Reset (async, any state, mid-run included): state=IDLE; complete=0, finish=0, running=0, timed_out=0, cycle_count=0, drain counter=0.
- All outputs are registered and change only on rising clk, except on reset assertion.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → RUN, cycle_count<=0, running<=1.
  - start=0 → stay in IDLE.
- RUN (every edge, cycle_count<=cycle_count+1), checked in this priority order:
  1. halt=1 → DRAIN; complete<=1; timed_out<=0.
  2. else cycle_count+1 == MAX_CYCLES-DRAIN_CYCLES → DRAIN; complete<=1; timed_out<=1.
  3. else stay in RUN.
  - Halt and budget hitting on the same edge: halt wins, timed_out=0.
- DRAIN:
  - cycle_count keeps incrementing; drain counter counts DRAIN_CYCLES edges.
  - On the DRAIN_CYCLES-th edge → DONE; finish<=1; running<=0; complete stays 1.
  - halt and start are ignored.
- DRAIN_CYCLES=0: RUN goes straight to DONE. complete and finish rise on the same edge, and running falls on that edge.
- DONE:
  - Terminal: complete=1 and finish=1 held, cycle_count frozen, timed_out held.
  - start is ignored; only reset leaves DONE.
- start is ignored outside IDLE. halt is ignored outside RUN, including when held high during IDLE, DRAIN or DONE.
- Timeout arithmetic: complete rises when cycle_count becomes MAX_CYCLES-DRAIN_CYCLES; finish rises when cycle_count becomes MAX_CYCLES.
- Halt arithmetic: if halt is sampled when cycle_count=N, complete rises with cycle_count=N+1, and finish rises with cycle_count=N+1+DRAIN_CYCLES.
- The counter never wraps within legal parameters.
- Implementation must be synthesizable: no `$time`, no `$finish`. The bench calls `$finish` on `finish`.

Test Plan:
1. Defaults; reset 2 cycles, pulse start one cycle, halt=0 → complete rises with cycle_count=99 and timed_out=1; finish rises with cycle_count=100; outputs frozen 20 more cycles.
2. Defaults; start, assert halt one cycle when cycle_count=40 → complete=1 at cycle_count=41, finish=1 at cycle_count=42, timed_out=0.
3. Defaults; halt asserted exactly on the edge where cycle_count+1=99 → DRAIN entered with timed_out=0; finish at cycle_count=100.
4. DRAIN_CYCLES=0, MAX_CYCLES=10; no halt → complete and finish rise together at cycle_count=10; running falls that edge.
5. Defaults; assert reset asynchronously (mid-cycle) at cycle_count=57 → all outputs 0 immediately, before the next edge; release, start again → a fresh run reaches finish at cycle_count=100.
6. halt=1 held while in IDLE, and start re-pulsed in RUN and DONE → no state change from either; run times out normally; DONE is not left until reset.
